// File: rtl/dsp_cmd_seq_if.sv
// Bundle of the sequencer's command, flush, DSP-slice and result signals.
// The slave modport is the sequencer's view. The master modport is the
// environment's view: control logic, slice and result consumer.
interface dsp_cmd_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [17:0] cmd_a;
  logic [17:0] cmd_b;
  logic [17:0] cmd_d;
  logic [47:0] cmd_c;
  logic [7:0]  cmd_opmode;
  logic        cmd_carryin;
  logic        flush;
  logic        flush_done;
  logic [17:0] dsp_a;
  logic [17:0] dsp_b;
  logic [17:0] dsp_d;
  logic [47:0] dsp_c;
  logic [7:0]  dsp_opmode;
  logic        dsp_carryin;
  logic        dsp_ce;
  logic        dsp_rst;
  logic [47:0] dsp_p;
  logic        dsp_carryout;
  logic        res_valid;
  logic        res_ready;
  logic [47:0] res_p;
  logic        res_carryout;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_d, cmd_c, cmd_opmode, cmd_carryin,
    output cmd_ready,
    input  flush,
    output flush_done,
    output dsp_a, dsp_b, dsp_d, dsp_c, dsp_opmode, dsp_carryin, dsp_ce, dsp_rst,
    input  dsp_p, dsp_carryout,
    output res_valid, res_p, res_carryout,
    input  res_ready
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_d, cmd_c, cmd_opmode, cmd_carryin,
    input  cmd_ready,
    output flush,
    input  flush_done,
    input  dsp_a, dsp_b, dsp_d, dsp_c, dsp_opmode, dsp_carryin, dsp_ce, dsp_rst,
    output dsp_p, dsp_carryout,
    input  res_valid, res_p, res_carryout,
    output res_ready
  );
endinterface

// File: rtl/dsp_cmd_seq.sv
// dsp_cmd_seq: command sequencer for a fully pipelined DSP48A1 slice.
//
// An accepted command is registered onto the slice inputs. A tag then
// follows it through a LATENCY-deep shift register. When the tag exits,
// the slice's P/carryout is pushed into a first-word-fall-through result
// FIFO. Credits (operations in flight plus FIFO occupancy) gate cmd_ready,
// so a push can never find the FIFO full.
//
// Optional feature macro: DSP_SEQ_STATS_EN. When it is defined, the port
// op_count is added. op_count counts result pops and saturates.
module dsp_cmd_seq #(
  parameter int LATENCY    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  dsp_cmd_seq_if.slave bus
`ifdef DSP_SEQ_STATS_EN
  ,
  output logic [15:0]  op_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] CREDITS = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_DRAIN} state_t;

  state_t        state_q;
  logic          init_cnt_q;
  logic          dsp_rst_q;
  logic          dsp_ce_q;
  logic          flush_done_q;

  logic [17:0]   dsp_a_q;
  logic [17:0]   dsp_b_q;
  logic [17:0]   dsp_d_q;
  logic [47:0]   dsp_c_q;
  logic [7:0]    dsp_op_q;
  logic          dsp_ci_q;

  // Bit 0 is the tag that travels with the dsp_* registers. Bits
  // 1..LATENCY follow the operation through the slice pipeline.
  logic [LATENCY:0] tag_q;
  logic [CW-1:0]    inflight_q;
  logic [CW-1:0]    count_q;
  logic [48:0]      mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;

  logic          cmd_ready;
  logic          accept;
  logic          push;
  logic          pop;
  logic          res_valid;
  logic [CW:0]   used;

  assign used      = {1'b0, inflight_q} + {1'b0, count_q};
  assign cmd_ready = (state_q == ST_RUN) && (used < CREDITS);
  assign accept    = bus.cmd_valid && cmd_ready;
  assign push      = tag_q[LATENCY];
  assign res_valid = (count_q != '0);
  assign pop       = res_valid && bus.res_ready;

  assign bus.cmd_ready    = cmd_ready;
  assign bus.flush_done   = flush_done_q;
  assign bus.dsp_a        = dsp_a_q;
  assign bus.dsp_b        = dsp_b_q;
  assign bus.dsp_d        = dsp_d_q;
  assign bus.dsp_c        = dsp_c_q;
  assign bus.dsp_opmode   = dsp_op_q;
  assign bus.dsp_carryin  = dsp_ci_q;
  assign bus.dsp_ce       = dsp_ce_q;
  assign bus.dsp_rst      = dsp_rst_q;
  assign bus.res_valid    = res_valid;
  assign bus.res_p        = res_valid ? mem_q[rd_ptr_q][47:0] : 48'd0;
  assign bus.res_carryout = res_valid ? mem_q[rd_ptr_q][48] : 1'b0;

  // Control FSM: two-cycle slice reset, then run/drain with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= 1'b0;
      dsp_rst_q    <= 1'b1;
      dsp_ce_q     <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q) begin
            state_q   <= ST_RUN;
            dsp_rst_q <= 1'b0;
            dsp_ce_q  <= 1'b1;
          end else begin
            init_cnt_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.flush) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (inflight_q == '0) begin
            flush_done_q <= 1'b1;
            state_q      <= ST_RUN;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

  // Stage p0: slice operand registers; bubbles drive zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dsp_a_q  <= '0;
      dsp_b_q  <= '0;
      dsp_d_q  <= '0;
      dsp_c_q  <= '0;
      dsp_op_q <= '0;
      dsp_ci_q <= 1'b0;
    end else begin
      dsp_a_q  <= accept ? bus.cmd_a       : 18'd0;
      dsp_b_q  <= accept ? bus.cmd_b       : 18'd0;
      dsp_d_q  <= accept ? bus.cmd_d       : 18'd0;
      dsp_c_q  <= accept ? bus.cmd_c       : 48'd0;
      dsp_op_q <= accept ? bus.cmd_opmode  : 8'd0;
      dsp_ci_q <= accept ? bus.cmd_carryin : 1'b0;
    end
  end

  // Latency tags and in-flight count: enter on accept, leave on FIFO push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q      <= '0;
      inflight_q <= '0;
    end else begin
      tag_q <= {tag_q[LATENCY-1:0], accept};
      case ({accept, push})
        2'b10:   inflight_q <= inflight_q + 1'b1;
        2'b01:   inflight_q <= inflight_q - 1'b1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // Result FIFO: captures slice output as the tag exits; credits prevent overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {bus.dsp_carryout, bus.dsp_p};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef DSP_SEQ_STATS_EN
  logic [15:0] op_count_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign op_count = op_count_q;

  // Pop statistics: saturating count of consumed results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_count_q <= '0;
    else if (pop) op_count_q <= sat_inc16(op_count_q);
  end
`endif

endmodule
